// File: rtl/inst_encoder.sv
// Program-load encoder: packs decoded instruction fields into 32-bit S/I/B words
// and streams them to instruction memory at sequential addresses from a base.
module inst_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [3:0]        in_opcode,
  input  logic [4:0]        in_src1,
  input  logic [4:0]        in_src2,
  input  logic [4:0]        in_dest,
  input  logic [4:0]        in_cond,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] TYPE_S = 2'b01;
  localparam logic [1:0] TYPE_I = 2'b10;
  localparam logic [1:0] TYPE_B = 2'b11;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic [31:0]       word;
  logic              lossy;

  assign accept = in_valid & in_ready;

  // Word packing and field-loss detection for the beat currently presented.
  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    word  = {26'd0, in_opcode, in_type};
    lossy = 1'b0;
    case (in_type)
      TYPE_S: begin
        word[31:6] = {11'd0, in_dest, in_src2, in_src1};
        lossy      = (|in_imm) | (|in_cond);
      end
      TYPE_I: begin
        word[31:6] = {in_imm, in_dest, in_src1};
        lossy      = (|in_src2) | (|in_cond);
      end
      TYPE_B: begin
        word[31:6] = {in_imm, in_cond, in_src1};
        lossy      = (|in_src2) | (|in_dest);
      end
      default: begin
        lossy = (|in_src1) | (|in_src2) | (|in_dest) | (|in_cond) | (|in_imm);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            addr      <= base_addr;
            err       <= 1'b0;
            err_count <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= word;
            addr    <= addr + 1'b1;
            // Counter at all-ones is about to wrap back to zero.
            if (lossy || (&addr)) err <= 1'b1;
            if (lossy && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (in_last) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized sessions
// compared against an arithmetic reference model of the word format and counters.
module tb_inst_encoder;

  localparam int AW = 10;

  typedef struct {
    logic [1:0]  t;
    logic [3:0]  op;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [4:0]  c;
    logic [15:0] imm;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_type;
  logic [3:0]    in_opcode;
  logic [4:0]    in_src1, in_src2, in_dest, in_cond;
  logic [15:0]   in_imm;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    err_count;

  inst_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_dest   (in_dest),
    .in_cond   (in_cond),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_addr;
  bit          m_err;
  int          m_cnt;
  int          last_addr;
  logic [31:0] last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word value as a sum of shifted fields.
  function automatic logic [31:0] encode(input beat_t b);
    int unsigned w;
    w = 32'(b.t) + 32'(b.op) * 4;
    case (b.t)
      2'd1: w = w + 32'(b.s1) * 64 + 32'(b.s2) * 2048 + 32'(b.d) * 65536;
      2'd2: w = w + 32'(b.s1) * 64 + 32'(b.d) * 2048 + 32'(b.imm) * 65536;
      2'd3: w = w + 32'(b.s1) * 64 + 32'(b.c) * 2048 + 32'(b.imm) * 65536;
      default: w = w + 0;
    endcase
    return w;
  endfunction

  // True when some field the type does not carry is nonzero.
  function automatic bit loses_field(input beat_t b);
    int unsigned dropped;
    case (b.t)
      2'd1:    dropped = 32'(b.imm) + 32'(b.c);
      2'd2:    dropped = 32'(b.s2) + 32'(b.c);
      2'd3:    dropped = 32'(b.s2) + 32'(b.d);
      default: dropped = 32'(b.s1) + 32'(b.s2) + 32'(b.d) + 32'(b.c) + 32'(b.imm);
    endcase
    return dropped != 0;
  endfunction

  function automatic beat_t rand_beat(input bit clean);
    beat_t b;
    b.t   = 2'($urandom);
    b.op  = 4'($urandom);
    b.s1  = 5'($urandom);
    b.s2  = 5'($urandom);
    b.d   = 5'($urandom);
    b.c   = 5'($urandom);
    b.imm = 16'($urandom);
    if (clean) begin
      case (b.t)
        2'd1: begin b.imm = '0; b.c = '0; end
        2'd2: begin b.s2 = '0; b.c = '0; end
        2'd3: begin b.s2 = '0; b.d = '0; end
        default: begin b.s1 = '0; b.s2 = '0; b.d = '0; b.c = '0; b.imm = '0; end
      endcase
    end
    return b;
  endfunction

  function automatic beat_t mk(input logic [1:0] t, input logic [3:0] op, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [4:0] d, input logic [4:0] c,
                               input logic [15:0] imm);
    beat_t b;
    b.t = t; b.op = op; b.s1 = s1; b.s2 = s2; b.d = d; b.c = c; b.imm = imm;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_type   = b.t;
    in_opcode = b.op;
    in_src1   = b.s1;
    in_src2   = b.s2;
    in_dest   = b.d;
    in_cond   = b.c;
    in_imm    = b.imm;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_data"},   wr_data,        32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    last_addr = 0;
    last_data = '0;
    m_err     = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic start_session(input int base);
    start     = 1'b1;
    base_addr = AW'(base);
    in_valid  = 1'b0;
    tick();
    start = 1'b0;
    m_addr = base;
    m_err  = 1'b0;
    m_cnt  = 0;
    check("start_in_ready",  32'(in_ready),  32'd1);
    check("start_busy",      32'(busy),      32'd1);
    check("start_wr_en",     32'(wr_en),     32'd0);
    check("start_err",       32'(err),       32'd0);
    check("start_err_count", 32'(err_count), 32'd0);
  endtask

  // One RUN cycle; a valid beat is always accepted since the bench only calls this in RUN.
  task automatic beat(input beat_t b, input bit valid, input bit last, input bit st, input bit st_done);
    logic [31:0] w;
    bit          lost;
    bit          fin;
    fin       = valid && last;
    in_valid  = valid;
    in_last   = last;
    start     = st;
    base_addr = AW'($urandom);
    drive(b);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (valid) begin
      w    = encode(b);
      lost = loses_field(b);
      check("wr_en",   32'(wr_en),   32'd1);
      check("wr_addr", 32'(wr_addr), 32'(m_addr));
      check("wr_data", wr_data,      w);
      last_addr = m_addr;
      last_data = w;
      m_addr    = (m_addr + 1) % (1 << AW);
      if (m_addr == 0 || lost) m_err = 1'b1;
      if (lost && m_cnt < 255) m_cnt++;
    end else begin
      check("gap_wr_en",   32'(wr_en),   32'd0);
      check("gap_wr_addr", 32'(wr_addr), 32'(last_addr));
      check("gap_wr_data", wr_data,      last_data);
    end
    check("err",       32'(err),       32'(m_err));
    check("err_count", 32'(err_count), 32'(m_cnt));
    check("done",      32'(done),      32'(fin));
    check("in_ready",  32'(in_ready),  32'(!fin));
    check("busy",      32'(busy),      32'd1);
    if (fin) begin
      // A beat offered in the DONE cycle must not be taken.
      in_valid = 1'b1;
      drive(rand_beat(1'b0));
      start = st_done;
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      check("post_busy",      32'(busy),      32'd0);
      check("post_in_ready",  32'(in_ready),  32'd0);
      check("post_done",      32'(done),      32'd0);
      check("post_wr_en",     32'(wr_en),     32'd0);
      check("post_wr_addr",   32'(wr_addr),   32'(last_addr));
      check("post_wr_data",   wr_data,        last_data);
      check("post_err",       32'(err),       32'(m_err));
      check("post_err_count", 32'(err_count), 32'(m_cnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b;
    int    n;
    int    gap_pct;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    drive(mk(2'd0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0));
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    // Beats offered in IDLE are ignored.
    in_valid = 1'b1;
    drive(mk(2'd1, 4'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0));
    tick();
    in_valid = 1'b0;
    check("idle_wr_en",    32'(wr_en),    32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Three back-to-back S beats from 0x010.
    start_session(32'h010);
    b = mk(2'd1, 4'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
    beat(b, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s_addr0", 32'(wr_addr), 32'h010);
    beat(b, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(b, 1'b1, 1'b1, 1'b0, 1'b0);
    check("s_addr2", 32'(wr_addr), 32'h012);
    check("s_err",   32'(err),     32'd0);

    // I then B.
    start_session(32'h040);
    beat(mk(2'd2, 4'd2, 5'd4, 5'd0, 5'd7, 5'd0, 16'hBEEF), 1'b1, 1'b0, 1'b0, 1'b0);
    check("i_word", wr_data, 32'hBEEF390A);
    beat(mk(2'd3, 4'hF, 5'd9, 5'd0, 5'd0, 5'd3, 16'h0010), 1'b1, 1'b1, 1'b0, 1'b0);
    check("b_word", wr_data, 32'h00101A7F);

    // Field loss on S (imm) and B (dest); next start clears the flags.
    start_session(32'h080);
    beat(mk(2'd1, 4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234), 1'b1, 1'b0, 1'b0, 1'b0);
    beat(mk(2'd3, 4'd6, 5'd2, 5'd0, 5'd1, 5'd4, 16'h00AA), 1'b1, 1'b1, 1'b0, 1'b0);
    check("loss_err",       32'(err),       32'd1);
    check("loss_err_count", 32'(err_count), 32'd2);
    start_session(32'h090);
    beat(mk(2'd2, 4'd3, 5'd1, 5'd0, 5'd2, 5'd0, 16'h0001), 1'b1, 1'b1, 1'b0, 1'b0);

    // Address wrap from the top of the space.
    start_session(32'h3FF);
    beat(mk(2'd1, 4'd2, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    beat(mk(2'd1, 4'd2, 5'd2, 5'd2, 5'd2, 5'd0, 16'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    check("wrap_addr",      32'(wr_addr),   32'h000);
    check("wrap_err",       32'(err),       32'd1);
    check("wrap_err_count", 32'(err_count), 32'd0);

    // Gapped valid with start pulses during RUN and DONE.
    start_session(32'h100);
    beat(mk(2'd2, 4'd7, 5'd5, 5'd0, 5'd6, 5'd0, 16'h5555), 1'b1, 1'b0, 1'b0, 1'b0);
    beat(mk(2'd2, 4'd7, 5'd5, 5'd0, 5'd6, 5'd0, 16'h6666), 1'b0, 1'b0, 1'b1, 1'b0);
    beat(mk(2'd3, 4'd8, 5'd7, 5'd0, 5'd0, 5'd2, 16'h7777), 1'b1, 1'b1, 1'b1, 1'b1);
    check("gap_last_addr", 32'(wr_addr), 32'h101);
    tick();
    check("gap_idle_in_ready", 32'(in_ready), 32'd0);
    check("gap_idle_busy",     32'(busy),     32'd0);

    // Reset coinciding with an offered beat discards it.
    start_session(32'h020);
    in_valid = 1'b1;
    drive(mk(2'd1, 4'd9, 5'd3, 5'd3, 5'd3, 5'd0, 16'd0));
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_reset("rst_same");

    // Reset the cycle after an accepted beat.
    start_session(32'h030);
    beat(mk(2'd2, 4'd4, 5'd8, 5'd0, 5'd9, 5'd0, 16'h0F0F), 1'b1, 1'b0, 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    drive(mk(2'd2, 4'd4, 5'd8, 5'd0, 5'd9, 5'd0, 16'h1111));
    tick();
    rst = 1'b0;
    check_reset("rst_mid");
    tick();
    in_valid = 1'b0;
    check("rst_mid_hold_ready", 32'(in_ready), 32'd0);
    check("rst_mid_hold_wr_en", 32'(wr_en),    32'd0);

    // Saturation of err_count: 270 lossy beats in one session.
    start_session(int'($urandom_range(0, 1023)));
    for (int i = 0; i < 270; i++) begin
      b      = rand_beat(1'b1);
      b.t    = 2'd0;
      b.s1   = 5'($urandom_range(1, 31));
      beat(b, 1'b1, (i == 269), 1'b0, 1'b0);
    end
    check("sat_err_count", 32'(err_count), 32'hFF);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      start_session(int'($urandom_range(0, 1023)));
      n       = int'($urandom_range(3, 40));
      gap_pct = int'($urandom_range(0, 50));
      for (int i = 0; i < n; i++) begin
        b = rand_beat($urandom_range(0, 99) < 50);
        if (i == n - 1)
          beat(b, 1'b1, 1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        else
          beat(b, $urandom_range(0, 99) >= gap_pct, 1'b0, $urandom_range(0, 3) == 0, 1'b0);
      end
      tick();
      check("rand_idle_in_ready", 32'(in_ready), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
